processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 The module SHALL have the port clk, an input, 1 bit wide, the single system clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, an input, 1 bit wide, a synchronous active-high reset.
REQ-003 The module SHALL have the port r3, an input, 8 bits wide, an external operand read as register R3.
REQ-004 The module SHALL have the port acc, an output, 8 bits wide, the accumulator register value.
REQ-005 The module SHALL have the port carry, an output, 1 bit wide, the carry/borrow flag, tied to 0 when PROCESSOR_CARRY_EN is undefined.

Function
REQ-006 The processor SHALL be a single-cycle accumulator machine: one instruction fetched from ROM[pc], decoded and executed per rising clk edge.
REQ-007 pc SHALL be 4 bits wide and SHALL address a 16x8 internal ROM; pc increments by 1 per instruction, wrapping 0xF->0x0, except on a taken jump.
REQ-008 The instruction format SHALL be [7:4] opcode and [3:0] operand; a register operand SHALL be Rn=operand[1:0].
REQ-009 The register file SHALL be R0-R2 (8-bit internal, written only by ST) plus R3, which SHALL read the live r3 port value.
REQ-010 Opcodes SHALL be: 0 NOP; 1 LDI acc={4'h0,imm}; 2 ADD acc+=Rn; 3 SUB acc-=Rn; 4 AND; 5 OR; 6 XOR acc op= Rn; 7 NOT acc=~acc; 8 SHL acc<<1; 9 SHR logical acc>>1; A LD acc=Rn; B ST Rn=acc; C JMP pc=operand; D JZ pc=operand if acc==0 else pc+1; E ADC acc+=Rn+carry; F JC pc=operand if carry==1.
REQ-011 All arithmetic SHALL be 8-bit modulo 256 with wrap-around and no saturation.
REQ-012 ST to R3 SHALL be ignored, with no register change.
REQ-013 JZ and JC SHALL test the acc and carry value held before the current edge.
REQ-014 acc SHALL be driven directly from the accumulator register, so an update is visible immediately after the executing edge.
REQ-015 The ROM SHALL hold fixed contents: 0x0 ADD R3 (0x23); 0x1 ADD R3 (0x23); 0x2 ST R0 (0xB0); 0x3 JMP 0x0 (0xC0); 0x4-0xF NOP (0x00).

Reset
REQ-016 While rst=1 at a rising edge, pc, acc, R0-R2 and carry SHALL all become 0 and no instruction SHALL execute.
REQ-017 rst SHALL have priority over any instruction, including mid-loop.
REQ-018 The first instruction executed SHALL be ROM[0], at the first rising edge with rst=0.

Configuration
REQ-019 When PROCESSOR_CARRY_EN is defined, ADD, ADC and SUB SHALL update carry (ADD/ADC carry-out of bit 7; SUB carry=1 on borrow, i.e. acc<Rn), all other opcodes SHALL preserve carry, and E and F SHALL behave as ADC and JC.
REQ-020 When PROCESSOR_CARRY_EN is undefined, carry SHALL be constant 0 and opcodes E and F SHALL execute as NOP (pc+1).

Verification
REQ-021 Addition: rst for 1 cycle, then r3=0x01 for 2 edges -> acc=0x01 then 0x02.
REQ-022 Loop: r3=0x01 for 8 edges after reset -> acc sequence 1,2,2,2,3,4,4,4, with R0=2 after edge 3.
REQ-023 Wrap: r3=0xFF for 2 edges after reset -> acc=0xFF then 0xFE; with PROCESSOR_CARRY_EN, carry=0 after edge 1 and 1 after edge 2; without it, carry=0 throughout.
REQ-024 Live operand: r3=0x03 at edge 1, then 0x05 at edge 2 -> acc=0x03 then 0x08.
REQ-025 Reset mid-operation: rst=1 at edge 6 of the loop -> acc=0 and carry=0; the next edge with rst=0 executes ROM[0] (acc=r3).

Source files
------------

// File: rtl/processor.sv
// processor: single-cycle 8-bit accumulator machine running a fixed 16x8 ROM.
// Define PROCESSOR_CARRY_EN to enable the carry flag, ADC (0xE) and JC (0xF).
module processor (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r3,
    output logic [7:0] acc,
    output logic       carry
);
    logic [3:0] pc_q, pc_d, op, opnd, pc_inc;
    logic [7:0] acc_q, acc_d, r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [7:0] instr, rv;
    logic [1:0] rn;

    assign instr = (pc_q == 4'h0 || pc_q == 4'h1) ? 8'h23 :
                   pc_q == 4'h2 ? 8'hB0 :
                   pc_q == 4'h3 ? 8'hC0 : 8'h00;
    assign op     = instr[7:4];
    assign opnd   = instr[3:0];
    assign rn     = opnd[1:0];
    assign pc_inc = pc_q + 4'h1;
    assign rv     = rn == 2'd0 ? r0_q : rn == 2'd1 ? r1_q : rn == 2'd2 ? r2_q : r3;
    assign acc    = acc_q;

`ifdef PROCESSOR_CARRY_EN
    logic       c_q, c_d;
    logic [8:0] add9, sub9, adc9;
    assign add9  = {1'b0, acc_q} + {1'b0, rv};
    assign sub9  = {1'b0, acc_q} - {1'b0, rv};
    assign adc9  = add9 + {8'h00, c_q};
    assign carry = c_q;

    always_ff @(posedge clk) begin
        if (rst) c_q <= 1'b0;
        else     c_q <= c_d;
    end
`else
    logic [7:0] add9, sub9;
    assign add9  = acc_q + rv;
    assign sub9  = acc_q - rv;
    assign carry = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_inc;
        acc_d = acc_q;
        r0_d  = r0_q;
        r1_d  = r1_q;
        r2_d  = r2_q;
`ifdef PROCESSOR_CARRY_EN
        c_d   = c_q;
`endif
        case (op)
            4'h1: acc_d = {4'h0, opnd};
`ifdef PROCESSOR_CARRY_EN
            4'h2: begin acc_d = add9[7:0]; c_d = add9[8]; end
            4'h3: begin acc_d = sub9[7:0]; c_d = sub9[8]; end
            4'hE: begin acc_d = adc9[7:0]; c_d = adc9[8]; end
            4'hF: pc_d = c_q ? opnd : pc_inc;
`else
            4'h2: acc_d = add9;
            4'h3: acc_d = sub9;
`endif
            4'h4: acc_d = acc_q & rv;
            4'h5: acc_d = acc_q | rv;
            4'h6: acc_d = acc_q ^ rv;
            4'h7: acc_d = ~acc_q;
            4'h8: acc_d = {acc_q[6:0], 1'b0};
            4'h9: acc_d = {1'b0, acc_q[7:1]};
            4'hA: acc_d = rv;
            4'hB: begin
                r0_d = rn == 2'd0 ? acc_q : r0_q;
                r1_d = rn == 2'd1 ? acc_q : r1_q;
                r2_d = rn == 2'd2 ? acc_q : r2_q;
            end
            4'hC: pc_d = opnd;
            4'hD: pc_d = acc_q == 8'h00 ? opnd : pc_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= 4'h0;
            acc_q <= 8'h00;
            r0_q  <= 8'h00;
            r1_q  <= 8'h00;
            r2_q  <= 8'h00;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            r0_q  <= r0_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
        end
    end
endmodule

// File: tb/tb_processor.sv
// tb_processor: scoreboard bench for processor; expectations queued by stimulus, checked by a monitor.
module tb_processor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r3 = 8'h00;
    logic [7:0] acc;
    logic       carry;
    int         checks = 0;
    int         failures = 0;

`ifdef PROCESSOR_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] acc;
        logic       c;
        bit         chk_r0;
        logic [7:0] r0;
    } exp_t;
    exp_t exp_q[$];

    processor dut (.clk(clk), .rst(rst), .r3(r3), .acc(acc), .carry(carry));

    always #5 clk = ~clk;

    task automatic step(input string name, input logic rst_v, input logic [7:0] r3_v,
                        input logic [7:0] e_acc, input logic e_c,
                        input bit chk_r0 = 1'b0, input logic [7:0] e_r0 = 8'h00);
        exp_t e;
        @(negedge clk);
        rst = rst_v;
        r3  = r3_v;
        e.name = name; e.acc = e_acc; e.c = e_c; e.chk_r0 = chk_r0; e.r0 = e_r0;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (acc !== e.acc) begin
                failures++;
                $display("FAIL %s acc: got %02h expected %02h", e.name, acc, e.acc);
            end
            checks++;
            if (carry !== e.c) begin
                failures++;
                $display("FAIL %s carry: got %0b expected %0b", e.name, carry, e.c);
            end
            if (e.chk_r0) begin
                checks++;
                if (dut.r0_q !== e.r0) begin
                    failures++;
                    $display("FAIL %s r0: got %02h expected %02h", e.name, dut.r0_q, e.r0);
                end
            end
        end
    end

    initial begin
        step("reset", 1'b1, 8'h00, 8'h00, 1'b0);
        // Addition: two ADD R3 with r3=1
        step("add1", 1'b0, 8'h01, 8'h01, 1'b0);
        step("add2", 1'b0, 8'h01, 8'h02, 1'b0);
        // Full loop: ADD, ADD, ST R0, JMP 0, repeated
        step("loop_rst", 1'b1, 8'h01, 8'h00, 1'b0);
        step("loop1", 1'b0, 8'h01, 8'h01, 1'b0);
        step("loop2", 1'b0, 8'h01, 8'h02, 1'b0);
        step("loop3", 1'b0, 8'h01, 8'h02, 1'b0, 1'b1, 8'h02);
        step("loop4", 1'b0, 8'h01, 8'h02, 1'b0, 1'b1, 8'h02);
        step("loop5", 1'b0, 8'h01, 8'h03, 1'b0);
        step("loop6", 1'b0, 8'h01, 8'h04, 1'b0);
        step("loop7", 1'b0, 8'h01, 8'h04, 1'b0, 1'b1, 8'h04);
        step("loop8", 1'b0, 8'h01, 8'h04, 1'b0);
        // Wrap-around with carry-out on the second ADD, preserved by ST/JMP
        step("wrap_rst", 1'b1, 8'hFF, 8'h00, 1'b0);
        step("wrap1", 1'b0, 8'hFF, 8'hFF, 1'b0);
        step("wrap2", 1'b0, 8'hFF, 8'hFE, CEN);
        step("wrap_st", 1'b0, 8'hFF, 8'hFE, CEN, 1'b1, 8'hFE);
        step("wrap_jmp", 1'b0, 8'hFF, 8'hFE, CEN);
        step("wrap_rst2", 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
        // Live operand: r3 changes between instructions
        step("live1", 1'b0, 8'h03, 8'h03, 1'b0);
        step("live2", 1'b0, 8'h05, 8'h08, 1'b0);
        // Reset in the middle of the loop, then restart at ROM[0]
        step("mid_rst", 1'b1, 8'h01, 8'h00, 1'b0);
        step("mid1", 1'b0, 8'h01, 8'h01, 1'b0);
        step("mid2", 1'b0, 8'h01, 8'h02, 1'b0);
        step("mid3", 1'b0, 8'h01, 8'h02, 1'b0);
        step("mid4", 1'b0, 8'h01, 8'h02, 1'b0);
        step("mid5", 1'b0, 8'h01, 8'h03, 1'b0);
        step("mid6_rst", 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00);
        step("after_rst", 1'b0, 8'h07, 8'h07, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
